// File: rtl/eth_phy_10g_pcs_pkg.sv
// Shared constants, slip FSM encoding and helpers for the 10GBASE-R PCS.
// Optional build macro PRBS31_EN adds the PRBS31 generator/checker helper.
package eth_phy_10g_pcs_pkg;

  localparam logic [1:0] SYNC_DATA       = 2'b01;
  localparam logic [1:0] SYNC_CTRL       = 2'b10;
  localparam logic [7:0] BLOCK_TYPE_CTRL = 8'h1E;
  localparam logic [7:0] XGMII_IDLE      = 8'h07;
  localparam logic [7:0] XGMII_ERROR     = 8'hFE;
  localparam logic [6:0] CTRL_IDLE       = 7'h00;
  localparam logic [6:0] CTRL_ERROR      = 7'h1E;

  typedef enum logic [1:0] {
    SLIP_IDLE,
    SLIP_HIGH,
    SLIP_LOW
  } slip_state_t;

  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

`ifdef PRBS31_EN
  typedef struct packed {
    logic [30:0] state;
    logic [65:0] bits;
  } prbs31_t;

  // Steps x^31+x^28+1 over 66 bits, bit 0 first. In check mode the LFSR is
  // fed from the received bits (self-synchronising) and bits[] holds the
  // per-bit mismatches; otherwise bits[] is the generated stream.
  function automatic prbs31_t prbs31_advance(input logic [30:0] seed,
                                             input logic [65:0] din,
                                             input logic        check);
    prbs31_t r;
    logic    pred;
    r.state = seed;
    r.bits  = '0;
    for (int unsigned i = 0; i < 66; i++) begin
      pred      = r.state[30] ^ r.state[27];
      r.bits[i] = check ? (din[i] ^ pred) : pred;
      r.state   = {r.state[29:0], (check ? din[i] : pred)};
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/eth_phy_10g_pcs_if.sv
// MAC (XGMII) and SERDES bus bundle for the 10GBASE-R PCS.
//   master : environment side (drives xgmii_txd/txc and serdes_rx_*)
//   slave  : PCS side (drives xgmii_rxd/rxc, serdes_tx_*, bitslip, reset req)
interface eth_phy_10g_pcs_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] xgmii_txd;
  logic [CTRL_WIDTH-1:0] xgmii_txc;
  logic [DATA_WIDTH-1:0] xgmii_rxd;
  logic [CTRL_WIDTH-1:0] xgmii_rxc;
  logic [DATA_WIDTH-1:0] serdes_tx_data;
  logic [HDR_WIDTH-1:0]  serdes_tx_hdr;
  logic [DATA_WIDTH-1:0] serdes_rx_data;
  logic [HDR_WIDTH-1:0]  serdes_rx_hdr;
  logic                  serdes_rx_bitslip;
  logic                  serdes_rx_reset_req;

  modport master (
    output xgmii_txd, xgmii_txc, serdes_rx_data, serdes_rx_hdr,
    input  xgmii_rxd, xgmii_rxc, serdes_tx_data, serdes_tx_hdr,
           serdes_rx_bitslip, serdes_rx_reset_req
  );

  modport slave (
    input  xgmii_txd, xgmii_txc, serdes_rx_data, serdes_rx_hdr,
    output xgmii_rxd, xgmii_rxc, serdes_tx_data, serdes_tx_hdr,
           serdes_rx_bitslip, serdes_rx_reset_req
  );
endinterface

// File: rtl/eth_phy_10g_pcs_frame_sync.sv
// Sync-header framing: counts headers in 64-block windows, maintains block
// lock and sequences bitslip requests (high phase then hold-off).
//   rx_hdr     : received sync header
//   block_lock : lock achieved
//   bitslip    : slip request to SERDES
//   slip_busy  : slip in progress, headers are ignored
module eth_phy_10g_pcs_frame_sync
  import eth_phy_10g_pcs_pkg::*;
#(
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] rx_hdr,
  output logic       block_lock,
  output logic       bitslip,
  output logic       slip_busy
);

  slip_state_t state_q, state_d;
  logic [7:0]  slip_cnt_q, slip_cnt_d;
  logic [5:0]  sh_cnt_q, sh_cnt_d;
  logic [3:0]  sh_inv_cnt_q, sh_inv_cnt_d;
  logic        lock_q, lock_d;
  logic        slip_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SLIP_IDLE;
      slip_cnt_q   <= '0;
      sh_cnt_q     <= '0;
      sh_inv_cnt_q <= '0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slip_cnt_q   <= slip_cnt_d;
      sh_cnt_q     <= sh_cnt_d;
      sh_inv_cnt_q <= sh_inv_cnt_d;
      lock_q       <= lock_d;
    end
  end

  // Header counting; only runs while no slip is in progress.
  always_comb begin
    sh_cnt_d     = sh_cnt_q;
    sh_inv_cnt_d = sh_inv_cnt_q;
    lock_d       = lock_q;
    slip_start   = 1'b0;
    if (state_q == SLIP_IDLE) begin
      if (hdr_valid(rx_hdr)) begin
        if (sh_cnt_q == '1) begin
          sh_cnt_d     = '0;
          sh_inv_cnt_d = '0;
          if (sh_inv_cnt_q == '0) lock_d = 1'b1;
        end else begin
          sh_cnt_d = sh_cnt_q + 6'd1;
        end
      end else if (!lock_q || (sh_inv_cnt_q == '1)) begin
        lock_d       = 1'b0;
        sh_cnt_d     = '0;
        sh_inv_cnt_d = '0;
        slip_start   = 1'b1;
      end else if (sh_cnt_q == '1) begin
        sh_cnt_d     = '0;
        sh_inv_cnt_d = '0;
      end else begin
        sh_cnt_d     = sh_cnt_q + 6'd1;
        sh_inv_cnt_d = sh_inv_cnt_q + 4'd1;
      end
    end
  end

  // Slip sequencer next state.
  always_comb begin
    state_d    = state_q;
    slip_cnt_d = slip_cnt_q;
    unique case (state_q)
      SLIP_IDLE: begin
        if (slip_start) begin
          state_d    = SLIP_HIGH;
          slip_cnt_d = '0;
        end
      end
      SLIP_HIGH: begin
        if (slip_cnt_q == 8'(BITSLIP_HIGH_CYCLES - 1)) begin
          state_d    = SLIP_LOW;
          slip_cnt_d = '0;
        end else begin
          slip_cnt_d = slip_cnt_q + 8'd1;
        end
      end
      SLIP_LOW: begin
        if (slip_cnt_q == 8'(BITSLIP_LOW_CYCLES - 1)) begin
          state_d    = SLIP_IDLE;
          slip_cnt_d = '0;
        end else begin
          slip_cnt_d = slip_cnt_q + 8'd1;
        end
      end
      default: state_d = SLIP_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bitslip    = (state_q == SLIP_HIGH);
    slip_busy  = (state_q != SLIP_IDLE);
    block_lock = lock_q;
  end

endmodule

// File: rtl/eth_phy_10g_pcs.sv
// Minimal 10GBASE-R PCS (no scrambler): 64b/66b TX encoder, RX frame sync,
// BER monitor, RX decoder and link status. TX and RX share clk.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : XGMII and SERDES buses (eth_phy_10g_pcs_if.slave)
//   tx_bad_block   : TX input not encodable
//   rx_bad_block   : RX block decoded as error
//   rx_error_count : saturating error count
//   rx_block_lock, rx_high_ber, rx_status : RX link state
// Build macro PRBS31_EN adds cfg_tx_prbs31_enable / cfg_rx_prbs31_enable
// and a PRBS31 test pattern generator and checker.
module eth_phy_10g_pcs
  import eth_phy_10g_pcs_pkg::*;
#(
  parameter int DATA_WIDTH          = 64,
  parameter int CTRL_WIDTH          = 8,
  parameter int HDR_WIDTH           = 2,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int COUNT_125US         = 125
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef PRBS31_EN
  input  logic                cfg_tx_prbs31_enable,
  input  logic                cfg_rx_prbs31_enable,
`endif
  eth_phy_10g_pcs_if.slave    bus,
  output logic                tx_bad_block,
  output logic                rx_bad_block,
  output logic [6:0]          rx_error_count,
  output logic                rx_block_lock,
  output logic                rx_high_ber,
  output logic                rx_status
);

  localparam int CYC_W = $clog2(COUNT_125US);

  logic [HDR_WIDTH-1:0]  tx_hdr_q, tx_hdr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_bad_q, tx_bad_d;
  logic [DATA_WIDTH-1:0] rxd_q, rxd_d;
  logic [CTRL_WIDTH-1:0] rxc_q, rxc_d;
  logic                  rx_bad_q, rx_bad_d;
  logic [6:0]            err_q, err_d;
  logic [CYC_W-1:0]      cyc_q, cyc_d;
  logic [3:0]            ber_q, ber_d;
  logic                  hber_q, hber_d;
  logic                  seen_q, seen_d;
  logic                  req_q, req_d;
  logic                  status_q, status_d;
  logic                  lock, slip_busy, bitslip, win_end;

  eth_phy_10g_pcs_frame_sync #(
    .BITSLIP_HIGH_CYCLES(BITSLIP_HIGH_CYCLES),
    .BITSLIP_LOW_CYCLES (BITSLIP_LOW_CYCLES)
  ) u_frame_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_hdr    (bus.serdes_rx_hdr),
    .block_lock(lock),
    .bitslip   (bitslip),
    .slip_busy (slip_busy)
  );

`ifdef PRBS31_EN
  logic [30:0] tx_lfsr_q, tx_lfsr_d, rx_lfsr_q, rx_lfsr_d;
  prbs31_t     tx_prbs, rx_prbs;
  logic [7:0]  prbs_err_bits, err_sum;

  always_comb begin
    tx_prbs       = prbs31_advance(tx_lfsr_q, '0, 1'b0);
    rx_prbs       = prbs31_advance(rx_lfsr_q, {bus.serdes_rx_data, bus.serdes_rx_hdr}, 1'b1);
    tx_lfsr_d     = cfg_tx_prbs31_enable ? tx_prbs.state : tx_lfsr_q;
    rx_lfsr_d     = cfg_rx_prbs31_enable ? rx_prbs.state : rx_lfsr_q;
    prbs_err_bits = 8'($countones(rx_prbs.bits));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_lfsr_q <= '1;
      rx_lfsr_q <= '1;
    end else begin
      tx_lfsr_q <= tx_lfsr_d;
      rx_lfsr_q <= rx_lfsr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_hdr_q  <= SYNC_CTRL;
      tx_data_q <= {{8{CTRL_IDLE}}, BLOCK_TYPE_CTRL};
      tx_bad_q  <= 1'b0;
      rxd_q     <= {8{XGMII_ERROR}};
      rxc_q     <= '1;
      rx_bad_q  <= 1'b0;
      err_q     <= '0;
      cyc_q     <= '0;
      ber_q     <= '0;
      hber_q    <= 1'b0;
      seen_q    <= 1'b0;
      req_q     <= 1'b0;
      status_q  <= 1'b0;
    end else begin
      tx_hdr_q  <= tx_hdr_d;
      tx_data_q <= tx_data_d;
      tx_bad_q  <= tx_bad_d;
      rxd_q     <= rxd_d;
      rxc_q     <= rxc_d;
      rx_bad_q  <= rx_bad_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
      ber_q     <= ber_d;
      hber_q    <= hber_d;
      seen_q    <= seen_d;
      req_q     <= req_d;
      status_q  <= status_d;
    end
  end

  // TX encoder; the error default also catches X on txc/txd.
  always_comb begin
    tx_hdr_d  = SYNC_CTRL;
    tx_data_d = {{8{CTRL_ERROR}}, BLOCK_TYPE_CTRL};
    tx_bad_d  = 1'b1;
    if (bus.xgmii_txc == '0) begin
      tx_hdr_d  = SYNC_DATA;
      tx_data_d = bus.xgmii_txd;
      tx_bad_d  = 1'b0;
    end else if ((bus.xgmii_txc == '1) && (bus.xgmii_txd == {8{XGMII_IDLE}})) begin
      tx_data_d = {{8{CTRL_IDLE}}, BLOCK_TYPE_CTRL};
      tx_bad_d  = 1'b0;
    end
`ifdef PRBS31_EN
    if (cfg_tx_prbs31_enable) begin
      tx_hdr_d  = tx_prbs.bits[1:0];
      tx_data_d = tx_prbs.bits[65:2];
      tx_bad_d  = 1'b0;
    end
`endif
  end

  // RX decoder and error counter.
  always_comb begin
    rxd_d    = {8{XGMII_ERROR}};
    rxc_d    = '1;
    rx_bad_d = lock;
    if (lock && (bus.serdes_rx_hdr == SYNC_DATA)) begin
      rxd_d    = bus.serdes_rx_data;
      rxc_d    = '0;
      rx_bad_d = 1'b0;
    end else if (lock && (bus.serdes_rx_hdr == SYNC_CTRL) &&
                 (bus.serdes_rx_data == {{8{CTRL_IDLE}}, BLOCK_TYPE_CTRL})) begin
      rxd_d    = {8{XGMII_IDLE}};
      rx_bad_d = 1'b0;
    end
    err_d = err_q;
    if (rx_bad_q && (err_q != '1)) err_d = err_q + 7'd1;
`ifdef PRBS31_EN
    err_sum = 8'(err_q) + prbs_err_bits;
    if (cfg_rx_prbs31_enable) begin
      rxd_d    = {8{XGMII_ERROR}};
      rxc_d    = '1;
      rx_bad_d = 1'b0;
      err_d    = (err_sum > 8'd127) ? '1 : err_sum[6:0];
    end
`endif
  end

  // BER window: the header arriving on the window-end cycle is counted
  // before the window is evaluated.
  always_comb begin
    win_end = (cyc_q == CYC_W'(COUNT_125US - 1));
    cyc_d   = win_end ? '0 : cyc_q + CYC_W'(1);
    ber_d   = ber_q;
    if (!hdr_valid(bus.serdes_rx_hdr) && !slip_busy && (ber_q != '1))
      ber_d = ber_q + 4'd1;
    hber_d = hber_q | (ber_d == '1);
    seen_d = seen_q | lock;
    req_d  = 1'b0;
    if (win_end) begin
      if (ber_d != '1) hber_d = 1'b0;
      ber_d  = '0;
      req_d  = ~(seen_q | lock);
      seen_d = 1'b0;
    end
    status_d = lock & ~hber_q;
  end

  assign bus.serdes_tx_hdr       = tx_hdr_q;
  assign bus.serdes_tx_data      = tx_data_q;
  assign bus.xgmii_rxd           = rxd_q;
  assign bus.xgmii_rxc           = rxc_q;
  assign bus.serdes_rx_bitslip   = bitslip;
  assign bus.serdes_rx_reset_req = req_q;
  assign tx_bad_block            = tx_bad_q;
  assign rx_bad_block            = rx_bad_q;
  assign rx_error_count          = err_q;
  assign rx_block_lock           = lock;
  assign rx_high_ber             = hber_q;
  assign rx_status               = status_q;

endmodule

// File: tb/tb_eth_phy_10g_pcs.sv
// Self-checking bench for eth_phy_10g_pcs: directed lock/slip/BER/loopback
// sequences plus randomized header traffic, all compared every cycle
// against a behavioural model of the PCS rules.
module tb_eth_phy_10g_pcs;

  localparam int HI  = 1;
  localparam int LO  = 8;
  localparam int WIN = 125;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_phy_10g_pcs_if bus_if ();
  logic       tx_bad_block, rx_bad_block, rx_block_lock, rx_high_ber, rx_status;
  logic [6:0] rx_error_count;

  eth_phy_10g_pcs #(
    .DATA_WIDTH(64), .CTRL_WIDTH(8), .HDR_WIDTH(2),
    .BITSLIP_HIGH_CYCLES(HI), .BITSLIP_LOW_CYCLES(LO), .COUNT_125US(WIN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef PRBS31_EN
    .cfg_tx_prbs31_enable(1'b0),
    .cfg_rx_prbs31_enable(1'b0),
`endif
    .bus           (bus_if),
    .tx_bad_block  (tx_bad_block),
    .rx_bad_block  (rx_bad_block),
    .rx_error_count(rx_error_count),
    .rx_block_lock (rx_block_lock),
    .rx_high_ber   (rx_high_ber),
    .rx_status     (rx_status)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int m_sh = 0, m_inv = 0, m_slip = 0, m_ber = 0, m_cyc = 0, e_err = 0;
  bit m_lock = 0, m_hber = 0, m_seen = 0;
  logic [63:0] e_rxd = {8{8'hFE}};
  logic [7:0]  e_rxc = 8'hFF;
  logic        e_bad = 0, e_status = 0, e_req = 0, e_txbad = 0;
  logic [1:0]  e_hdr = 2'b10;
  logic [63:0] e_txdata = 64'h1E;
  bit loop = 0;

  logic [63:0] s_txd, s_rdata;
  logic [7:0]  s_txc;
  logic [1:0]  s_rhdr;

  task automatic model_step();
    bit inv, in_slip, wend, nh;
    int nb;
    if (e_bad && e_err < 127) e_err++;
    e_status = m_lock && !m_hber;
    if (m_lock && s_rhdr == 2'b01) begin
      e_rxd = s_rdata; e_rxc = 8'h00; e_bad = 0;
    end else if (m_lock && s_rhdr == 2'b10 && s_rdata == 64'h1E) begin
      e_rxd = {8{8'h07}}; e_rxc = 8'hFF; e_bad = 0;
    end else begin
      e_rxd = {8{8'hFE}}; e_rxc = 8'hFF; e_bad = m_lock;
    end
    if (s_txc == 8'h00) begin
      e_hdr = 2'b01; e_txdata = s_txd; e_txbad = 0;
    end else if (s_txc == 8'hFF && s_txd == {8{8'h07}}) begin
      e_hdr = 2'b10; e_txdata = 64'h1E; e_txbad = 0;
    end else begin
      e_hdr = 2'b10; e_txdata = {{8{7'h1E}}, 8'h1E}; e_txbad = 1;
    end
    inv = (s_rhdr == 2'b00) || (s_rhdr == 2'b11);
    in_slip = (m_slip > 0);
    wend = (m_cyc == WIN - 1);
    nb = m_ber;
    if (inv && !in_slip && nb < 15) nb++;
    nh = m_hber || (nb == 15);
    e_req = 0;
    if (wend) begin
      e_req = !(m_seen || m_lock);
      m_seen = 0;
      if (nb < 15) nh = 0;
      nb = 0;
      m_cyc = 0;
    end else begin
      m_seen = m_seen || m_lock;
      m_cyc++;
    end
    m_ber = nb;
    m_hber = nh;
    if (in_slip) m_slip--;
    else if (!inv) begin
      if (m_sh == 63) begin
        if (m_inv == 0) m_lock = 1;
        m_sh = 0; m_inv = 0;
      end else m_sh++;
    end else if (!m_lock || m_inv == 15) begin
      m_lock = 0; m_sh = 0; m_inv = 0; m_slip = HI + LO;
    end else if (m_sh == 63) begin
      m_sh = 0; m_inv = 0;
    end else begin
      m_sh++; m_inv++;
    end
  endtask

  task automatic compare_all();
    check_eq("rxd", bus_if.xgmii_rxd, e_rxd);
    check_eq("rxc", bus_if.xgmii_rxc, e_rxc);
    check_eq("rx_bad_block", rx_bad_block, e_bad);
    check_eq("rx_error_count", rx_error_count, e_err[6:0]);
    check_eq("rx_block_lock", rx_block_lock, m_lock);
    check_eq("rx_high_ber", rx_high_ber, m_hber);
    check_eq("rx_status", rx_status, e_status);
    check_eq("bitslip", bus_if.serdes_rx_bitslip, m_slip > LO);
    check_eq("reset_req", bus_if.serdes_rx_reset_req, e_req);
    check_eq("tx_hdr", bus_if.serdes_tx_hdr, e_hdr);
    check_eq("tx_data", bus_if.serdes_tx_data, e_txdata);
    check_eq("tx_bad_block", tx_bad_block, e_txbad);
  endtask

  task automatic tick();
    s_txd = bus_if.xgmii_txd; s_txc = bus_if.xgmii_txc;
    s_rhdr = bus_if.serdes_rx_hdr; s_rdata = bus_if.serdes_rx_data;
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    if (loop) begin
      bus_if.serdes_rx_hdr  = bus_if.serdes_tx_hdr;
      bus_if.serdes_rx_data = bus_if.serdes_tx_data;
    end
  endtask

  task automatic tx_idle();
    bus_if.xgmii_txc = 8'hFF; bus_if.xgmii_txd = {8{8'h07}};
  endtask

  task automatic rand_tx();
    case ($urandom_range(3))
      0: begin bus_if.xgmii_txc = 8'h00; bus_if.xgmii_txd = {$urandom, $urandom}; end
      1: tx_idle();
      2: begin bus_if.xgmii_txc = 8'hFF; bus_if.xgmii_txd = {$urandom, $urandom}; end
      default: begin bus_if.xgmii_txc = 8'($urandom); bus_if.xgmii_txd = {$urandom, $urandom}; end
    endcase
  endtask

  task automatic rx_set(input logic [1:0] h, input logic [63:0] d);
    bus_if.serdes_rx_hdr = h; bus_if.serdes_rx_data = d;
  endtask

  task automatic rx_rand_valid();
    if ($urandom_range(1) == 0) rx_set(2'b01, {$urandom, $urandom});
    else if ($urandom_range(1) == 0) rx_set(2'b10, 64'h1E);
    else rx_set(2'b10, {$urandom, $urandom});
  endtask

  task automatic run_blocks(input int n, input logic [1:0] h);
    for (int i = 0; i < n; i++) begin
      rx_set(h, (h == 2'b10) ? 64'h1E : {$urandom, $urandom});
      tick();
    end
  endtask

  task automatic run_rand(input int n, input int pinv);
    for (int i = 0; i < n; i++) begin
      rand_tx();
      if ($urandom_range(99) < pinv) rx_set($urandom_range(1) ? 2'b11 : 2'b00, {$urandom, $urandom});
      else rx_rand_valid();
      tick();
    end
  endtask

  initial begin
    tx_idle();
    rx_set(2'b10, 64'h1E);
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Acquire lock on 64 idle control blocks
    run_blocks(63, 2'b10);
    check_eq("lock_before_64th", rx_block_lock, 1'b0);
    run_blocks(1, 2'b10);
    check_eq("lock_after_64th", rx_block_lock, 1'b1);

    // Loopback: data block round trip, then an unencodable block
    loop = 1;
    bus_if.xgmii_txc = 8'h00; bus_if.xgmii_txd = 64'h0706050403020100;
    tick();
    tx_idle();
    tick();
    check_eq("rt_rxd", bus_if.xgmii_rxd, 64'h0706050403020100);
    check_eq("rt_rxc", bus_if.xgmii_rxc, 8'h00);
    bus_if.xgmii_txc = 8'h01; bus_if.xgmii_txd = 64'h07070707070707FB;
    tick();
    check_eq("tx_bad_fb", tx_bad_block, 1'b1);
    tx_idle();
    tick();
    check_eq("rx_err_rxd", bus_if.xgmii_rxd, {8{8'hFE}});
    check_eq("rx_bad_fb", rx_bad_block, 1'b1);
    tick();
    check_eq("err_count_one", rx_error_count, 7'd1);
    for (int i = 0; i < 60; i++) begin
      rand_tx();
      tick();
    end
    loop = 0;
    tx_idle();

    // 15 invalid headers at a BER window start: lock held, high BER
    for (int i = 0; i < 2 * WIN && m_cyc != 0; i++) run_blocks(1, 2'b10);
    run_blocks(15, 2'b00);
    check_eq("lock_held_15", rx_block_lock, 1'b1);
    check_eq("high_ber_15", rx_high_ber, 1'b1);
    run_blocks(2 * WIN + 5, 2'b10);
    check_eq("high_ber_cleared", rx_high_ber, 1'b0);
    check_eq("status_back", rx_status, 1'b1);

    // 16 invalid headers inside one 64-block window: lock lost, slip
    for (int i = 0; i < 70 && !(m_lock && m_sh == 0); i++) run_blocks(1, 2'b10);
    run_blocks(15, 2'b11);
    check_eq("lock_at_15th", rx_block_lock, 1'b1);
    run_blocks(1, 2'b00);
    check_eq("lock_lost_16th", rx_block_lock, 1'b0);
    check_eq("slip_on_16th", bus_if.serdes_rx_bitslip, 1'b1);
    run_blocks(1, 2'b10);
    check_eq("slip_low_after", bus_if.serdes_rx_bitslip, 1'b0);
    run_blocks(LO - 1, 2'b10);

    // Unlocked: 62 valid then one invalid slips and restarts the count
    run_blocks(62, 2'b01);
    run_blocks(1, 2'b00);
    check_eq("slip_unlocked", bus_if.serdes_rx_bitslip, 1'b1);
    run_blocks(HI + LO + 63, 2'b10);
    check_eq("relock_pre", rx_block_lock, 1'b0);
    run_blocks(1, 2'b10);
    check_eq("relock", rx_block_lock, 1'b1);

    // Randomized traffic
    run_rand(300, 2);
    run_rand(300, 25);
    run_rand(150, 0);
    run_rand(250, 6);
    loop = 1;
    for (int i = 0; i < 100; i++) begin
      rand_tx();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_phy_10g_pcs.md
Name: eth_phy_10g_pcs

Overview:
- Minimal 10GBASE-R PCS between a 64-bit XGMII-style MAC interface and a 64b/66b SERDES (64-bit data + 2-bit sync header).
- TX path: encodes data and idle blocks.
- RX path: performs block lock (sync-header framing with bitslip), BER monitoring, decoding and link status.
- No scrambler; TX and RX share one clock.

Parameters:
- DATA_WIDTH, 64, data width; only 64 supported.
- CTRL_WIDTH, 8, XGMII control width (DATA_WIDTH/8).
- HDR_WIDTH, 2, sync header width.
- BITSLIP_HIGH_CYCLES, 1, cycles serdes_rx_bitslip stays high per slip.
- BITSLIP_LOW_CYCLES, 8, hold-off cycles after a slip; headers are ignored during hold-off.
- COUNT_125US, 125, clock cycles in one 125 us BER window (small value for simulation).

Ports:
- clk  in  1  TX/RX clock.
- rst_n  in  1  asynchronous active-low reset.
- xgmii_txd  in  64  TX data; byte0 = bits 7:0.
- xgmii_txc  in  8  TX control; one bit per byte.
- xgmii_rxd  out  64  RX decoded data.
- xgmii_rxc  out  8  RX decoded control.
- serdes_tx_data  out  64  TX block payload.
- serdes_tx_hdr  out  2  TX sync header.
- serdes_rx_data  in  64  RX block payload.
- serdes_rx_hdr  in  2  RX sync header.
- serdes_rx_bitslip  out  1  slip request to SERDES.
- serdes_rx_reset_req  out  1  one-cycle SERDES reset request.
- tx_bad_block  out  1  TX input not encodable.
- rx_bad_block  out  1  RX block decoded as error.
- rx_error_count  out  7  saturating error counter.
- rx_block_lock  out  1  block lock achieved.
- rx_high_ber  out  1  high bit-error-rate flag.
- rx_status  out  1  link OK.

Behaviour:
- Reset: all outputs are 0, except:
  - xgmii_rxd = 64'hFEFE_FEFE_FEFE_FEFE and xgmii_rxc = 8'hFF;
  - serdes_tx_hdr = 2'b10 and serdes_tx_data = 64'h1E (idle block).
- TX encoder, registered, latency 1:
  - txc = 0 → hdr 01, data = txd.
  - txc = FF and all bytes 07 → hdr 10, data = 64'h1E (type 1E, eight 7-bit idle codes 0).
  - Anything else, including X → hdr 10, data = {eight 7-bit 1E error codes, 8'h1E}, and tx_bad_block = 1 that cycle.
- Header classification: 01 and 10 are valid; 00 and 11 are invalid.
- Frame sync, per block, counters sh_cnt (6 bit) and sh_inv_cnt (4 bit):
  - Valid header: sh_cnt++. If sh_cnt was 63: clear both counters, and if sh_inv_cnt == 0 set rx_block_lock.
  - Invalid header: sh_cnt++ and sh_inv_cnt++.
  - Invalid header while unlocked, or while sh_inv_cnt == 15 (16th invalid in the window): clear rx_block_lock, clear both counters, start a slip.
  - Otherwise, invalid header with sh_cnt == 63: clear both counters.
- Consequences of the frame-sync rules:
  - Lock asserts the cycle after the 64th consecutive valid header.
  - Up to 15 invalid headers in a 64-block window keep lock.
- Slip: bitslip high for BITSLIP_HIGH_CYCLES, then low for BITSLIP_LOW_CYCLES. Headers are ignored during the whole slip. A new slip cannot start until the current slip completes.
- BER monitor:
  - Cycle counter wraps every COUNT_125US cycles; ber_cnt is 4 bit.
  - Invalid header while not in a slip → ber_cnt++, saturating at 15. Reaching 15 sets rx_high_ber immediately.
  - At window end: if ber_cnt < 15, clear rx_high_ber. In all cases clear ber_cnt.
- serdes_rx_reset_req: one-cycle pulse at a window end if rx_block_lock stayed 0 for the entire window.
- RX decoder, registered, latency 1:
  - Locked and hdr 01 → rxd = data, rxc = 0.
  - Locked and hdr 10 with data == 64'h1E → rxd = 0707…07, rxc = FF.
  - Otherwise → rxd = FEFE…FE, rxc = FF.
  - rx_bad_block = 1 only when locked and the error case occurs.
- rx_error_count: increments on each rx_bad_block, saturates at 127, cleared only by reset.
- rx_status: registered rx_block_lock & ~rx_high_ber.
- Simultaneous events: lock loss overrides a window-completion lock set. The BER window end in the same cycle as an invalid header counts that header first, then evaluates.

Optional Feature:
- Macro PRBS31_EN.
- When defined:
  - Adds ports cfg_tx_prbs31_enable and cfg_rx_prbs31_enable (in, 1 each).
  - With TX enabled: serdes_tx_hdr/data carry a PRBS31 (x^31+x^28+1) stream, 66 bits per cycle, header first; the LFSR is seeded all-ones.
  - With RX enabled: the checker self-synchronises; rx_error_count adds mismatched bits (saturating) instead of bad blocks; decoder output is forced to error.
- When undefined: no ports, no PRBS logic.

Decomposition:
- Package eth_phy_10g_pcs_pkg: SYNC_DATA = 2'b01, SYNC_CTRL = 2'b10, BLOCK_TYPE_CTRL = 8'h1E, XGMII_IDLE = 8'h07, XGMII_ERROR = 8'hFE, CTRL_IDLE = 7'h00, CTRL_ERROR = 7'h1E.
- One sub-module, eth_phy_10g_pcs_frame_sync: header counting, lock and bitslip.

Test Plan:
- Reset, then 64 blocks with hdr 10 → rx_block_lock 0→1 the cycle after block 64; bitslip stays 0.
- 62 valid, 1 hdr 00 while unlocked → bitslip pulse (1 cycle), counters cleared; lock needs a further 64 valid.
- 64 valid (locked), 15 hdr 00, then valid → lock held; rx_high_ber = 1 until the first window end with ber_cnt < 15; rx_status 1→0→1.
- 64 valid, 16 hdr 00 → lock drops on the 16th invalid; bitslip high 1 cycle, then 8 hold-off cycles; rx_status = 0.
- Locked; txd = 64'h0706050403020100 with txc = 0 looped to rx → rxd equals txd, rxc = 0, 2-cycle round trip.
- txc = 01 with txd byte0 = FB → tx_bad_block = 1; looped back: rxd = FE…FE, rx_bad_block = 1, rx_error_count = 1.
